pdp_mem_multiport: RTL and testbench
====================================

// Module: pdp_mem_multiport
// PURPOSE
//  - Parametrised PDP-8 main memory. One write port, NUM_RD independent read ports (IFU, exec, debug ...).
//  - Read latency is configurable; read-during-write behaviour is selectable per instance.
//  - Optional post-reset initialisation sweep with a ready flag.
//  - Sits between the IFU/exec units and the storage array; drop-in successor to the two-read/one-write PDP memory.
// PARAMETERS
//  DATA_W      12    word width in bits
//  DEPTH       4096  number of words; AW = $clog2(DEPTH)
//  NUM_RD      2     number of read ports (1..4)
//  RD_LATENCY  1     request-to-data cycles (1 or 2)
//  WRITE_FIRST 1     1: same-cycle same-address read returns new data; 0: returns old data
//  INIT_SWEEP  1     1: after reset, fill mem[a] = a (truncated/zero-extended to DATA_W); 0: contents untouched
// PORTS
//  clk       in   1             single clock; all logic on posedge
//  reset_n   in   1             synchronous, active-low reset
//  rd_req    in   NUM_RD        per-port read request, sampled on posedge
//  rd_addr   in   NUM_RD*AW     port p address in bits [p*AW +: AW]
//  rd_data   out  NUM_RD*DATA_W port p data in bits [p*DATA_W +: DATA_W]
//  rd_valid  out  NUM_RD        one-cycle pulse per accepted request
//  wr_req    in   1             write request
//  wr_addr   in   AW            write address
//  wr_data   in   DATA_W        write data
//  ready     out  1             1 = accepting requests; 0 during the init sweep
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): ready=0, rd_valid=0, rd_data=0, all pipeline stages cleared.
//    State goes to MEM_INIT if INIT_SWEEP=1, else MEM_RUN. Mid-operation reset drops in-flight reads.
//  - MEM_INIT: sweep counter 0..DEPTH-1 writes one word per cycle. ready=0.
//    Cycle after writing DEPTH-1: ready=1, state MEM_RUN.
//    With INIT_SWEEP=0, ready=1 on the first posedge after reset release.
//  - While ready=0, rd_req and wr_req are ignored: no rd_valid, no array write.
//  - Read: rd_req[p]=1 at posedge N gives rd_valid[p]=1 and rd_data valid after posedge N+RD_LATENCY.
//    Fully pipelined; back-to-back requests give back-to-back valids.
//    rd_data holds its last value when no valid is pending.
//  - Ports are independent. Any number may hit the same address in the same cycle; all get the same word.
//  - Write: wr_req=1 at posedge N updates the array at N; a read issued at N+1 sees the new data.
//  - Collision (wr_req and rd_req[p], wr_addr==rd_addr[p], same posedge):
//    WRITE_FIRST=1 returns wr_data; WRITE_FIRST=0 returns the pre-write word.
//  - Out-of-range address (>= DEPTH, non-power-of-2 DEPTH only): read returns 0 with valid; write dropped.
//  - Latency-2 stage carries both the valid bit and the data; no other state.
// STRUCTURE
//  - pdp8_pkg additions: PDP_MEM_DEPTH=4096, PDP_DATA_W=12, typedef enum logic {MEM_INIT, MEM_RUN} mem_state_e.
//  - Sub-module pdp_mem_rd_pipe: one read port's collision mux, latency pipeline and valid tracking.
//    Instantiated NUM_RD times in a generate loop.
//  - Top level holds the array, write logic, sweep counter and the state register.
// TESTING (DATA_W=12, DEPTH=4096, NUM_RD=2 unless stated)
//  1. INIT_SWEEP=1, release reset -> ready low exactly 4096 cycles, then high.
//     Read port0 0x0A5 -> 0x0A5 one cycle later.
//  2. Write 0x123 @0x200 at N; read port1 0x200 at N+1 -> rd_valid[1] and 0x123 at N+2.
//  3. Same cycle: write 0x7FF @0x010 and read port0 0x010.
//     WRITE_FIRST=1 -> 0x7FF; WRITE_FIRST=0 -> 0x010. Subsequent read -> 0x7FF.
//  4. RD_LATENCY=2: both ports stream 8 consecutive reads (port0 0x001.., port1 0xFFF..).
//     Valids continuous for 8 cycles starting N+2, data in order.
//  5. Assert reset_n=0 at sweep count 100 -> ready stays 0, in-flight valid dropped.
//     Sweep restarts at 0; ready rises 4096 cycles after release.
//  6. While ready=0, pulse rd_req and write 0xABC @0x300 -> no rd_valid.
//     After ready, read 0x300 -> 0x300.

Source files
------------

// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - PDP-8 shared constants and types for the main memory
package pdp8_pkg;

    localparam int PDP_MEM_DEPTH = 4096;
    localparam int PDP_DATA_W    = 12;

    // MEM_INIT: post-reset sweep in progress, requests ignored.
    // MEM_RUN : normal operation.
    typedef enum logic {MEM_INIT, MEM_RUN} mem_state_e;

endpackage

// File: rtl/pdp_mem_rd_pipe.sv
// rtl/pdp_mem_rd_pipe.sv - one read port: collision mux, latency pipeline, valid tracking
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   i_req          read request already qualified by memory ready
//   i_addr         read address
//   i_in_range     i_addr < DEPTH
//   i_mem_data     array word at i_addr (pre-write contents this cycle)
//   i_wr_en        a user write lands in the array this cycle
//   i_wr_addr      write address
//   i_wr_data      write data
//   o_valid        one-cycle pulse RD_LATENCY cycles after i_req
//   o_data         read word; holds its last value between valids
module pdp_mem_rd_pipe
    import pdp8_pkg::*;
#(
    parameter int DATA_W      = PDP_DATA_W,
    parameter int AW          = 12,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_in_range,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              w_hit;
    logic [DATA_W-1:0] w_sel;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // The array read returns the pre-write word because the write is
    // non-blocking; write-first instances bypass the write data instead.
    assign w_hit = (WRITE_FIRST != 0) && i_wr_en && (i_wr_addr == i_addr);

    always_comb begin
        w_sel = i_mem_data;
        if (!i_in_range) begin
            w_sel = '0;
        end else if (w_hit) begin
            w_sel = i_wr_data;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              r_v1;
            logic [DATA_W-1:0] r_d1;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_v1    <= 1'b0;
                    r_d1    <= '0;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_v1    <= i_req;
                    if (i_req) begin
                        r_d1 <= w_sel;
                    end
                    r_valid <= r_v1;
                    if (r_v1) begin
                        r_data <= r_d1;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= i_req;
                    if (i_req) begin
                        r_data <= w_sel;
                    end
                end
            end
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pdp_mem_multiport.sv
// rtl/pdp_mem_multiport.sv - PDP-8 main memory, one write port and NUM_RD read ports
//
// Ports:
//   clk       clock, all logic on posedge
//   reset_n   synchronous active-low reset
//   rd_req    per-port read request
//   rd_addr   port p address in [p*AW +: AW]
//   rd_data   port p data in [p*DATA_W +: DATA_W]
//   rd_valid  per-port one-cycle valid pulse
//   wr_req    write request
//   wr_addr   write address
//   wr_data   write data
//   ready     1 when requests are accepted, 0 during reset and the init sweep
module pdp_mem_multiport
    import pdp8_pkg::*;
#(
    parameter int DATA_W      = PDP_DATA_W,
    parameter int DEPTH       = PDP_MEM_DEPTH,
    parameter int NUM_RD      = 2,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1,
    parameter int INIT_SWEEP  = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_req,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    mem_state_e        r_state;
    logic [AW-1:0]     r_sweep;
    logic              r_ready;

    logic              w_wr_in_range;
    logic              w_user_we;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign w_user_we     = r_ready && wr_req && w_wr_in_range;

    // Sweep and user writes are exclusive: ready is low throughout MEM_INIT.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        if (r_state == MEM_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
            w_wdata = DATA_W'(r_sweep);
        end else if (w_user_we) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= (INIT_SWEEP != 0) ? MEM_INIT : MEM_RUN;
            r_sweep <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                MEM_INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == LAST_A) begin
                        r_state <= MEM_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic              w_in_range;
        logic [DATA_W-1:0] w_mem_rd;

        assign w_addr     = rd_addr[p*AW +: AW];
        assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
        assign w_mem_rd   = r_mem[w_addr];

        pdp_mem_rd_pipe #(
            .DATA_W      (DATA_W),
            .AW          (AW),
            .RD_LATENCY  (RD_LATENCY),
            .WRITE_FIRST (WRITE_FIRST)
        ) u_rd_pipe (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_req      (r_ready && rd_req[p]),
            .i_addr     (w_addr),
            .i_in_range (w_in_range),
            .i_mem_data (w_mem_rd),
            .i_wr_en    (w_user_we),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .o_valid    (rd_valid[p]),
            .o_data     (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pdp_mem_multiport.sv
// tb/tb_pdp_mem_multiport.sv - scoreboard bench for pdp_mem_multiport
module tb_pdp_mem_multiport;

    localparam int NI = 3;
    localparam int NS = NI * 2;

    // instance 0: lat 1, write-first, sweep, depth 4096
    // instance 1: lat 2, read-first,  sweep, depth 4096
    // instance 2: lat 2, write-first, no sweep, depth 3000
    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic bit wf_of(input int i);
        return (i != 1);
    endfunction
    function automatic bit sw_of(input int i);
        return (i != 2);
    endfunction
    function automatic int dep_of(input int i);
        return (i == 2) ? 3000 : 4096;
    endfunction

    typedef struct {
        logic [11:0] d;
        bit          care;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rd_req;
    logic [23:0] rd_addr;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [11:0] wr_data;
    logic [23:0] rdat [NI];
    logic [1:0]  rval [NI];
    logic        rdy  [NI];

    always #5 clk = ~clk;

    pdp_mem_multiport #(.DATA_W(12), .DEPTH(4096), .NUM_RD(2), .RD_LATENCY(1),
                        .WRITE_FIRST(1), .INIT_SWEEP(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rdat[0]), .rd_valid(rval[0]), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .ready(rdy[0]));

    pdp_mem_multiport #(.DATA_W(12), .DEPTH(4096), .NUM_RD(2), .RD_LATENCY(2),
                        .WRITE_FIRST(0), .INIT_SWEEP(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rdat[1]), .rd_valid(rval[1]), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .ready(rdy[1]));

    pdp_mem_multiport #(.DATA_W(12), .DEPTH(3000), .NUM_RD(2), .RD_LATENCY(2),
                        .WRITE_FIRST(1), .INIT_SWEEP(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rdat[2]), .rd_valid(rval[2]), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .ready(rdy[2]));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          m_rdy  [NI];
    bit          m_sw   [NI];
    int          m_cnt  [NI];
    logic [11:0] mm     [NI][4096];
    bit          mk     [NI][4096];
    exp_t        q      [NS][$];
    logic [11:0] last_d [NS];
    bit          last_c [NS];

    always @(posedge clk) begin : model
        exp_t e;
        int   a;
        bit   acc_w;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) begin
                m_rdy[i] = 1'b0;
                m_sw[i]  = sw_of(i);
                m_cnt[i] = 0;
                for (int p = 0; p < 2; p++) begin
                    q[i*2+p].delete();
                    last_d[i*2+p] = 12'h000;
                    last_c[i*2+p] = 1'b1;
                end
            end else begin
                acc_w = m_rdy[i] && wr_req && (int'(wr_addr) < dep_of(i));
                for (int p = 0; p < 2; p++) begin
                    if (m_rdy[i] && rd_req[p]) begin
                        a = int'(rd_addr[p*12 +: 12]);
                        if (a >= dep_of(i)) begin
                            e.d = 12'h000; e.care = 1'b1;
                        end else if (acc_w && wf_of(i) && int'(wr_addr) == a) begin
                            e.d = wr_data; e.care = 1'b1;
                        end else begin
                            e.d = mm[i][a]; e.care = mk[i][a];
                        end
                        e.due = cyc + lat_of(i) - 1;
                        q[i*2+p].push_back(e);
                    end
                end
                if (acc_w) begin
                    mm[i][wr_addr] = wr_data;
                    mk[i][wr_addr] = 1'b1;
                end
                if (m_sw[i]) begin
                    mm[i][m_cnt[i]] = 12'(m_cnt[i]);
                    mk[i][m_cnt[i]] = 1'b1;
                    if (m_cnt[i] == dep_of(i) - 1) begin
                        m_sw[i]  = 1'b0;
                        m_rdy[i] = 1'b1;
                    end
                    m_cnt[i]++;
                end else begin
                    m_rdy[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    bit mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        v;
        logic [11:0] d;
        if (mon_en) begin
            for (int s = 0; s < NS; s++) begin
                v = rval[s/2][s%2];
                d = rdat[s/2][(s%2)*12 +: 12];
                if (v) begin
                    if (q[s].size() == 0) begin
                        check($sformatf("unexpected_valid i%0d p%0d cyc%0d", s/2, s%2, cyc), int'(v), 0);
                    end else begin
                        e = q[s].pop_front();
                        check($sformatf("valid_timing i%0d p%0d", s/2, s%2), cyc, e.due);
                        if (e.care) begin
                            check($sformatf("rd_data i%0d p%0d cyc%0d", s/2, s%2, cyc), int'(d), int'(e.d));
                        end
                        last_d[s] = e.d;
                        last_c[s] = e.care;
                    end
                end else if (q[s].size() != 0 && q[s][0].due <= cyc) begin
                    check($sformatf("missing_valid i%0d p%0d cyc%0d", s/2, s%2, cyc), int'(v), 1);
                    void'(q[s].pop_front());
                end else if (last_c[s]) begin
                    check($sformatf("rd_data_hold i%0d p%0d cyc%0d", s/2, s%2, cyc), int'(d), int'(last_d[s]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        rd_req = 2'b00;
        wr_req = 1'b0;
    endtask

    task automatic rd(input int p, input int a);
        rd_req[p] = 1'b1;
        rd_addr[p*12 +: 12] = 12'(a);
    endtask

    task automatic wr(input int a, input int d);
        wr_req  = 1'b1;
        wr_addr = 12'(a);
        wr_data = 12'(d);
    endtask

    initial begin : stim
        int first [NI];
        int n;
        int a;
        reset_n = 1'b0;
        rd_req  = 2'b00;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_ready i%0d", i), int'(rdy[i]), 0);
            check($sformatf("reset_valid i%0d", i), int'(rval[i]), 0);
            check($sformatf("reset_data i%0d", i), int'(rdat[i]), 0);
        end

        // First release: requests during the sweep must be ignored
        reset_n = 1'b1;
        tick();
        check("noswp_ready_first_edge", int'(rdy[2]), 1);
        rd(0, 'h300); rd(1, 'h300); wr('h300, 'hABC);
        tick();
        repeat (97) tick();
        check("sweep_ready_low a", int'(rdy[0]), 0);
        check("sweep_ready_low b", int'(rdy[1]), 0);
        // A read in flight on the latency-2 no-sweep instance, killed by reset
        rd(0, 'h005); rd(1, 'h006);
        tick();
        reset_n = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midreset_ready i%0d", i), int'(rdy[i]), 0);
        end
        tick();

        // Second release: measure ready rise per instance
        reset_n = 1'b1;
        for (int i = 0; i < NI; i++) first[i] = 0;
        n = 0;
        while (n < 5000 && (first[0] == 0 || first[1] == 0 || first[2] == 0)) begin
            tick();
            n++;
            for (int i = 0; i < NI; i++) begin
                if (rdy[i] && first[i] == 0) first[i] = n;
            end
        end
        check("ready_rise a", first[0], 4096);
        check("ready_rise b", first[1], 4096);
        check("ready_rise c", first[2], 1);

        // Sweep contents and the ignored write
        rd(0, 'h0A5); rd(1, 'h300);
        tick();
        tick();

        // Write then read next cycle
        wr('h200, 'h123);
        tick();
        rd(1, 'h200);
        tick();

        // Same-cycle collision, then a follow-up read
        wr('h010, 'h7FF); rd(0, 'h010);
        tick();
        rd(0, 'h010);
        tick();

        // Back-to-back streaming on both ports
        for (int k = 0; k < 8; k++) begin
            rd(0, 1 + k); rd(1, 'hFFF - k);
            tick();
        end
        repeat (3) tick();

        // Range boundary on the 3000-deep instance
        wr('hBB7, 'h1A2);
        tick();
        wr('hC00, 'h5A5);
        tick();
        rd(0, 'hBB7); rd(1, 'hC00);
        tick();

        // Both ports on the same address
        rd(0, 'h200); rd(1, 'h200);
        tick();

        // Random traffic around a small window that straddles address 3000
        for (int k = 0; k < 300; k++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = $urandom_range(0, 15) + ((($urandom & 3) == 0) ? 'hBB0 : 'h0F0);
                    rd(p, a);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 15) + ((($urandom & 3) == 0) ? 'hBB0 : 'h0F0);
                wr(a, $urandom_range(0, 4095));
            end
            tick();
        end

        repeat (6) tick();
        for (int s = 0; s < NS; s++) begin
            check($sformatf("drain_empty s%0d", s), q[s].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

endmodule
